pll_lock_ctrl: RTL and testbench

Lock supervisor on the consumer side of the Gowin PLLVR camera/video clock generators. It drives the PLL `RESET` pin, watches the PLL `LOCK` output, retries on lock timeout, and releases a downstream reset only after lock has been continuously stable. It runs on the PLL's reference clock (27 MHz board oscillator), so it keeps working while the PLL output is absent. It sits between each `*_pll` instance and the logic clocked by that PLL (camera XCLK domain, HDMI pixel domain).

---
 rtl/pll_lock_pkg.sv | 32 +++
 rtl/sync_2ff.sv | 22 ++
 rtl/pll_lock_ctrl.sv | 129 ++++++++++++
 tb/tb_pll_lock_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_pkg.sv
// Shared types and width helpers for the PLL lock supervisor.
package pll_lock_pkg;

  typedef enum logic [2:0] {
    ST_RST_PULSE = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  // Timer width sized from the longest interval it must count; never below 1 bit.
  function automatic int unsigned tmr_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    int unsigned w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

  // Width of a counter that must hold 0..n inclusive; never below 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; the first may go metastable, the second filters it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL lock supervisor: pulses PLL reset, waits for stable lock, retries on
// timeout and releases the PLL-clocked domain reset only in RUN.
module pll_lock_ctrl
  import pll_lock_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 27,
  parameter int unsigned LOCK_TIMEOUT  = 27000,
  parameter int unsigned STABLE_CYCLES = 2700,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             pll_lock,
  input  logic                             restart,
  output logic                             pll_reset,
  output logic                             out_rst_n,
  output logic                             ready,
  output logic                             fail,
  output logic [cnt_width(MAX_RETRY)-1:0]  retry_cnt,
  output logic [7:0]                       loss_cnt
);

  localparam int unsigned TMR_W   = tmr_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned RETRY_W = cnt_width(MAX_RETRY);

  localparam logic [TMR_W-1:0]   RST_LAST    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0]   LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

  state_e               state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [RETRY_W-1:0]   retry_d;
  logic [7:0]           loss_d;
  logic                 pll_reset_d, run_d, fail_d;
  logic                 lock_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // State register, shared timer, counters and Moore outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RST_PULSE;
      tmr_q     <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      pll_reset <= 1'b1;
      out_rst_n <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      retry_cnt <= retry_d;
      loss_cnt  <= loss_d;
      pll_reset <= pll_reset_d;
      out_rst_n <= run_d;
      ready     <= run_d;
      fail      <= fail_d;
    end
  end

  // Next-state, counter updates and output decode from the next state.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    retry_d = retry_cnt;
    loss_d  = loss_cnt;

    if (restart) begin
      state_d = ST_RST_PULSE;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RST_PULSE: begin
          tmr_d = tmr_q + TMR_W'(1);
          if (tmr_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          tmr_d = tmr_q + TMR_W'(1);
          if (lock_s) begin
            state_d = ST_STABLE;
          end else if (tmr_q == LOCK_LAST) begin
            if (retry_cnt == RETRY_MAX) begin
              state_d = ST_FAIL;
            end else begin
              retry_d = retry_cnt + RETRY_W'(1);
              state_d = ST_RST_PULSE;
            end
          end
        end
        ST_STABLE: begin
          tmr_d = tmr_q + TMR_W'(1);
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (tmr_q == STABLE_LAST) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            if (loss_cnt != 8'hFF) loss_d = loss_cnt + 8'd1;
            retry_d = '0;
            state_d = ST_RST_PULSE;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_RST_PULSE;
        end
      endcase
    end

    // Timer restarts on every state change and on any restart request.
    if (restart || (state_d != state_q)) tmr_d = '0;

    pll_reset_d = (state_d == ST_RST_PULSE) || (state_d == ST_FAIL);
    run_d       = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
  end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with short timing parameters.
module tb_pll_lock_ctrl;

  localparam int unsigned RST_C = 4;
  localparam int unsigned LT    = 20;
  localparam int unsigned SC    = 8;
  localparam int unsigned MR    = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       restart;
  logic       pll_reset;
  logic       out_rst_n;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int n;

  always #5 clk = ~clk;

  pll_lock_ctrl #(
    .RST_CYCLES    (RST_C),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .MAX_RETRY     (MR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .restart   (restart),
    .pll_reset (pll_reset),
    .out_rst_n (out_rst_n),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Advance one clock; drive and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles until pll_reset rises (bounded).
  task automatic wait_rise(output int cnt);
    cnt = 0;
    while (!pll_reset && cnt < 100) begin tick(); cnt++; end
  endtask

  // Length of the current pll_reset pulse, counting the cycle already seen high.
  task automatic count_high(output int cnt);
    cnt = 0;
    while (pll_reset && cnt < 100) begin cnt++; tick(); end
  endtask

  // Cycles from pll_reset falling until it rises again (bounded).
  task automatic count_low(output int cnt);
    cnt = 0;
    while (!pll_reset && cnt < 100) begin tick(); cnt++; end
  endtask

  // Cycles until ready rises (bounded).
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready && cnt < 100) begin tick(); cnt++; end
  endtask

  initial begin
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    restart  = 1'b0;
    repeat (3) tick();
    check("rst_pll_reset", pll_reset, 1);
    check("rst_out_rst_n", out_rst_n, 0);
    check("rst_ready",     ready,     0);
    check("rst_fail",      fail,      0);
    check("rst_retry",     retry_cnt, 0);
    check("rst_loss",      loss_cnt,  0);

    // Power-up: 4-cycle pulse, lock 5 cycles later, RUN 3+8 cycles after lock.
    rst_n = 1'b1;
    repeat (3) tick();
    check("pulse0_last_hi", pll_reset, 1);
    tick();
    check("pulse0_fall", pll_reset, 0);
    repeat (5) tick();
    pll_lock = 1'b1;
    wait_ready(n);
    check("lock_to_ready", n, 11);
    check("run_out_rst_n", out_rst_n, 1);
    check("run_pll_reset", pll_reset, 0);
    check("run_retry",     retry_cnt, 0);

    // Lock loss in RUN.
    pll_lock = 1'b0;
    wait_rise(n);
    check("loss_latency",  n, 3);
    check("loss_out_rst",  out_rst_n, 0);
    check("loss_ready",    ready, 0);
    check("loss_cnt_1",    loss_cnt, 1);
    count_high(n);
    check("loss_pulse_len", n, 4);
    pll_lock = 1'b1;
    wait_ready(n);
    check("relock_ready", n, 11);

    // 299 more losses: counter saturates.
    for (int i = 0; i < 299; i++) begin
      pll_lock = 1'b0;
      wait_rise(n);
      count_high(n);
      pll_lock = 1'b1;
      wait_ready(n);
    end
    check("loss_saturated", loss_cnt, 255);
    check("sat_ready",      ready, 1);

    // One timeout, then a lock glitch at stable count 5.
    pll_lock = 1'b0;
    wait_rise(n);
    count_high(n);
    count_low(n);
    check("timeout_gap",   n, 20);
    check("timeout_retry", retry_cnt, 1);
    count_high(n);
    check("retry_pulse_len", n, 4);
    pll_lock = 1'b1;
    repeat (8) tick();
    check("stable_not_ready", ready, 0);
    pll_lock = 1'b0;
    repeat (2) tick();
    pll_lock = 1'b1;
    wait_ready(n);
    check("glitch_relock", n, 11);
    check("glitch_retry",  retry_cnt, 1);
    check("glitch_loss",   loss_cnt, 255);

    // Lock held low: three pulses then FAIL.
    pll_lock = 1'b0;
    wait_rise(n);
    for (int p = 0; p < 3; p++) begin
      count_high(n);
      check($sformatf("fail_seq_pulse%0d", p), n, 4);
      count_low(n);
      check($sformatf("fail_seq_gap%0d", p), n, 20);
      check($sformatf("fail_seq_retry%0d", p), retry_cnt, (p < 2) ? p + 1 : 2);
      check($sformatf("fail_seq_fail%0d", p), fail, (p == 2) ? 1 : 0);
    end
    repeat (30) tick();
    check("fail_hold_reset", pll_reset, 1);
    check("fail_hold_fail",  fail, 1);
    check("fail_ready",      ready, 0);
    check("fail_out_rst_n",  out_rst_n, 0);

    // Restart out of FAIL.
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_fail",  fail, 0);
    check("restart_reset", pll_reset, 1);
    check("restart_retry", retry_cnt, 0);
    check("restart_loss",  loss_cnt, 255);
    count_high(n);
    check("restart_pulse_len", n, 4);
    count_low(n);
    check("restart_gap", n, 20);
    check("restart_retry1", retry_cnt, 1);
    count_high(n);

    // Restart in the same cycle as a timeout wins.
    repeat (19) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("collide_retry", retry_cnt, 0);
    check("collide_reset", pll_reset, 1);

    // Restart mid-pulse restarts the pulse timer.
    repeat (2) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    count_high(n);
    check("extended_pulse_tail", n, 4);

    // Async reset mid-STABLE, checked before the next rising edge.
    pll_lock = 1'b1;
    repeat (6) tick();
    check("pre_arst_reset", pll_reset, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_pll_reset", pll_reset, 1);
    check("arst_out_rst_n", out_rst_n, 0);
    check("arst_ready",     ready, 0);
    check("arst_fail",      fail, 0);
    check("arst_retry",     retry_cnt, 0);
    check("arst_loss",      loss_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
